// File: rtl/qea_state_reader.sv
// qea_state_reader
// Host-side readback engine for the QEA state RAM. After a run it reads
// every state-RAM word in ascending address order, splits each word into
// PE_NUM complex amplitudes (MSB slice first) and streams them out one per
// beat on a valid/ready interface together with their global index.
//
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-high reset
//   i_start         - begin readback (sampled in IDLE only)
//   i_qbit_num      - qubit count, sampled with i_start
//   i_abort         - synchronous abort back to IDLE
//   o_busy          - high whenever not IDLE
//   o_done          - one-cycle pulse after the final beat
//   o_err           - one-cycle pulse on a rejected start
//   o_state_ena     - per-PE read enable toward QEA (all ones in READ)
//   o_state_wea     - write enable toward QEA, always zero
//   o_state_addra   - state-RAM word address
//   i_state_dout    - QEA read data, valid RD_LATENCY cycles after enable
//   o_amp_valid/i_amp_ready - amplitude stream handshake
//   o_amp_data      - one complex amplitude {re, im}
//   o_amp_index     - global amplitude index = addr*PE_NUM + k
//   o_amp_last      - marks the final amplitude of the run
module qea_state_reader #(
    parameter int PE_NUM_WIDTH     = 2,
    parameter int PE_NUM           = 4,
    parameter int STATE_DATA_WIDTH = 64,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH   = 6,
    parameter int RD_LATENCY       = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]                i_qbit_num,
    input  logic                                     i_abort,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic                                     o_err,
    output logic [PE_NUM-1:0]                        o_state_ena,
    output logic [PE_NUM-1:0]                        o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]              o_state_addra,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]       i_state_dout,
    output logic                                     o_amp_valid,
    input  logic                                     i_amp_ready,
    output logic [STATE_DATA_WIDTH-1:0]              o_amp_data,
    output logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_amp_index,
    output logic                                     o_amp_last
);
    localparam int W   = STATE_DATA_WIDTH;
    localparam int AW1 = STATE_ADDR_WIDTH + 1;
    localparam int CW  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t                    state_q, state_d;
    // One spare address bit so a full 2^STATE_ADDR_WIDTH-word run ends cleanly.
    logic [AW1-1:0]            addr_q, addr_d;
    logic [AW1-1:0]            last_addr_q, last_addr_d;
    logic [CW-1:0]             wait_cnt_q, wait_cnt_d;
    logic [PE_NUM_WIDTH-1:0]   k_q, k_d;
    logic [PE_NUM*W-1:0]       buf_q, buf_d;
    logic                      err_q, err_d;

    logic                      start_ok;
    logic [MAX_QBIT_WIDTH-1:0] shamt;
    logic                      k_last;
    logic                      addr_last;

    assign start_ok  = (int'(i_qbit_num) >= PE_NUM_WIDTH) &&
                       (int'(i_qbit_num) <= PE_NUM_WIDTH + STATE_ADDR_WIDTH);
    assign shamt     = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    assign k_last    = (k_q == PE_NUM_WIDTH'(PE_NUM - 1));
    assign addr_last = (addr_q == last_addr_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        wait_cnt_d  = wait_cnt_q;
        k_d         = k_q;
        buf_d       = buf_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (start_ok) begin
                        addr_d      = '0;
                        k_d         = '0;
                        last_addr_d = (AW1'(1) << shamt) - AW1'(1);
                        state_d     = S_READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                wait_cnt_d = CW'(RD_LATENCY - 1);
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == '0) begin
                    buf_d   = i_state_dout;
                    k_d     = '0;
                    state_d = S_EMIT;
                end else begin
                    wait_cnt_d = wait_cnt_q - CW'(1);
                end
            end
            S_EMIT: begin
                if (i_amp_ready) begin
                    if (k_last) begin
                        k_d = '0;
                        if (addr_last) begin
                            state_d = S_FINISH;
                        end else begin
                            addr_d  = addr_q + AW1'(1);
                            state_d = S_READ;
                        end
                    end else begin
                        k_d = k_q + PE_NUM_WIDTH'(1);
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort outranks any handshake or progress made above.
        if (i_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            k_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            wait_cnt_q  <= '0;
            k_q         <= '0;
            buf_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            wait_cnt_q  <= wait_cnt_d;
            k_q         <= k_d;
            buf_q       <= buf_d;
            err_q       <= err_d;
        end
    end

    // Beat k carries the k-th slice counted from the MSB end of the word.
    always_comb begin
        o_amp_data = '0;
        for (int unsigned i = 0; i < PE_NUM; i++) begin
            if (k_q == PE_NUM_WIDTH'(i)) begin
                o_amp_data = buf_q[(PE_NUM-1-i)*W +: W];
            end
        end
    end

    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = (state_q == S_FINISH);
    assign o_err         = err_q;
    assign o_state_ena   = (state_q == S_READ) ? '1 : '0;
    assign o_state_wea   = '0;
    assign o_state_addra = addr_q[STATE_ADDR_WIDTH-1:0];
    assign o_amp_valid   = (state_q == S_EMIT);
    assign o_amp_index   = {addr_q[STATE_ADDR_WIDTH-1:0], k_q};
    assign o_amp_last    = o_amp_valid && k_last && addr_last;

endmodule

// File: tb/tb_qea_state_reader.sv
module tb_qea_state_reader;
    localparam int PNW = 2;
    localparam int PE  = 4;
    localparam int W   = 64;
    localparam int AW  = 16;
    localparam int QW  = 6;
    localparam int LAT = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                i_start = 1'b0;
    logic [QW-1:0]       i_qbit_num = '0;
    logic                i_abort = 1'b0;
    logic                o_busy, o_done, o_err;
    logic [PE-1:0]       o_state_ena, o_state_wea;
    logic [AW-1:0]       o_state_addra;
    logic [PE*W-1:0]     i_state_dout = '0;
    logic                o_amp_valid;
    logic                i_amp_ready = 1'b1;
    logic [W-1:0]        o_amp_data;
    logic [AW+PNW-1:0]   o_amp_index;
    logic                o_amp_last;

    int checks = 0;
    int errors = 0;

    qea_state_reader #(
        .PE_NUM_WIDTH(PNW), .PE_NUM(PE), .STATE_DATA_WIDTH(W),
        .STATE_ADDR_WIDTH(AW), .MAX_QBIT_WIDTH(QW), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_qbit_num(i_qbit_num),
        .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea),
        .o_state_addra(o_state_addra), .i_state_dout(i_state_dout),
        .o_amp_valid(o_amp_valid), .i_amp_ready(i_amp_ready),
        .o_amp_data(o_amp_data), .o_amp_index(o_amp_index),
        .o_amp_last(o_amp_last)
    );

    always #5 clk = ~clk;

    // ---------------- state RAM model (two-cycle read latency) -----------
    bit          basic_mode = 1'b0;
    logic        p_en = 1'b0;
    logic [AW-1:0] p_addr = '0;

    function automatic logic [63:0] amp(input int unsigned i);
        logic [31:0] hi, lo;
        hi = i * 32'h9E3779B1;
        lo = i ^ 32'hA5A50000;
        return {hi, lo};
    endfunction

    function automatic logic [PE*W-1:0] word_of(input logic [AW-1:0] a);
        logic [PE*W-1:0] w;
        w = '0;
        for (int k = 0; k < PE; k++) begin
            if (basic_mode)
                w[(PE-1-k)*W +: W] = (a == 0 && k == 0) ? 64'h40000000_00000000 : 64'h0;
            else
                w[(PE-1-k)*W +: W] = amp(int'(a) * PE + k);
        end
        return w;
    endfunction

    always @(posedge clk) begin
        p_en   <= |o_state_ena;
        p_addr <= o_state_addra;
        i_state_dout <= p_en ? word_of(p_addr) : {16{16'hDEAD}};
    end

    // ---------------- passive monitor -------------------------------------
    int          rd_cnt = 0, rd_bad = 0, wea_bad = 0;
    int          done_cnt = 0, err_cnt = 0, last_cnt = 0;
    logic [AW-1:0] exp_rd_addr = '0;

    always @(negedge clk) begin
        if (o_state_ena != '0) begin
            if (o_state_ena !== 4'hF || o_state_addra !== exp_rd_addr) rd_bad++;
            exp_rd_addr++;
            rd_cnt++;
        end
        if (o_state_wea !== '0) wea_bad++;
        if (o_done)     done_cnt++;
        if (o_err)      err_cnt++;
        if (o_amp_last) last_cnt++;
    end

    task automatic clear_mon;
        rd_cnt = 0; rd_bad = 0; done_cnt = 0; err_cnt = 0; last_cnt = 0;
        exp_rd_addr = '0;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Stimulus only: start a run and let it proceed for n cycles.
    task automatic run_start(input int q, input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            i_start     = (c == 0);
            i_qbit_num  = QW'(q);
            i_amp_ready = 1'b1;
        end
        i_start = 1'b0;
    endtask

    // ---------------- tests -----------------------------------------------
    task automatic test_reset;
        #1 rst = 1'b1;
        tick();
        checks++;
        if ({o_busy, o_done, o_err, o_state_ena, o_state_wea, o_state_addra,
             o_amp_valid, o_amp_index, o_amp_last, o_amp_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b ena=%h valid=%b idx=%0d data=%h, required all 0",
                     o_busy, o_state_ena, o_amp_valid, o_amp_index, o_amp_data);
        end
        i_start = 1'b1; i_qbit_num = 6'd2;
        tick(); tick();
        checks++;
        if (o_busy !== 1'b0 || o_state_ena !== '0) begin
            errors++;
            $display("FAIL reset_hold: busy=%b ena=%h, required 0/0", o_busy, o_state_ena);
        end
        i_start = 1'b0;
        rst = 1'b0;
        tick();
        clear_mon();
    endtask

    task automatic test_basic;
        logic [3:0]  exp_ena;
        logic [63:0] exp_data;
        basic_mode = 1'b1;
        clear_mon();
        for (int c = 0; c <= 10; c++) begin
            tick();
            i_start = (c == 0); i_qbit_num = 6'd2; i_amp_ready = 1'b1;
            exp_ena = (c == 1) ? 4'hF : 4'h0;
            checks++;
            if (o_state_ena !== exp_ena || (c == 1 && o_state_addra !== '0)) begin
                errors++;
                $display("FAIL basic_ena c=%0d: ena=%h addr=%0d, required ena=%h addr=0",
                         c, o_state_ena, o_state_addra, exp_ena);
            end
            checks++;
            if (o_amp_valid !== (c >= 4 && c <= 7)) begin
                errors++;
                $display("FAIL basic_valid c=%0d: got %b", c, o_amp_valid);
            end
            if (c >= 4 && c <= 7) begin
                exp_data = (c == 4) ? 64'h40000000_00000000 : 64'h0;
                checks++;
                if (o_amp_data !== exp_data || o_amp_index !== 18'(c - 4) ||
                    o_amp_last !== (c == 7)) begin
                    errors++;
                    $display("FAIL basic_beat c=%0d: data=%h idx=%0d last=%b, required data=%h idx=%0d last=%b",
                             c, o_amp_data, o_amp_index, o_amp_last, exp_data, c - 4, (c == 7));
                end
            end
            checks++;
            if (o_done !== (c == 8) || o_busy !== (c >= 1 && c <= 8) || o_err !== 1'b0) begin
                errors++;
                $display("FAIL basic_ctrl c=%0d: done=%b busy=%b err=%b, required done=%b busy=%b err=0",
                         c, o_done, o_busy, o_err, (c == 8), (c >= 1 && c <= 8));
            end
        end
        i_start = 1'b0;
        basic_mode = 1'b0;
    endtask

    task automatic test_full_14;
        int first_read = -1, done_cyc = -1, beats = 0;
        clear_mon();
        for (int c = 0; c < 40000; c++) begin
            tick();
            i_start = (c == 0); i_qbit_num = 6'd14; i_amp_ready = 1'b1;
            if (o_state_ena != '0 && first_read < 0) first_read = c;
            if (o_amp_valid) begin
                checks++;
                if (o_amp_index !== 18'(beats) || o_amp_data !== amp(beats) ||
                    o_amp_last !== (beats == 16383)) begin
                    errors++;
                    $display("FAIL full_beat %0d: idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                             beats, o_amp_index, o_amp_data, o_amp_last, beats, amp(beats), (beats == 16383));
                end
                beats++;
            end
            if (o_done) begin done_cyc = c; break; end
        end
        i_start = 1'b0;
        checks++;
        if (done_cyc < 0 || done_cyc - first_read != 28672) begin
            errors++;
            $display("FAIL full_done_time: done-first_read=%0d, required 28672", done_cyc - first_read);
        end
        checks++;
        if (beats != 16384) begin
            errors++;
            $display("FAIL full_beats: got %0d, required 16384", beats);
        end
        checks++;
        if (rd_cnt != 4096 || rd_bad != 0) begin
            errors++;
            $display("FAIL full_reads: count=%0d bad=%0d, required 4096/0", rd_cnt, rd_bad);
        end
        checks++;
        if (last_cnt != 1) begin
            errors++;
            $display("FAIL full_last_count: got %0d, required 1", last_cnt);
        end
        tick();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL full_busy_fall: busy=%b, required 0", o_busy);
        end
    endtask

    task automatic test_backpressure;
        int beats = 0, stall_left = 0, stall_seen = 0;
        bit stall_done = 0, prev_stall = 0, done_seen = 0;
        logic [W-1:0] pd; logic [AW+PNW-1:0] pi; logic pl;
        clear_mon();
        for (int c = 0; c < 2000; c++) begin
            tick();
            i_start = (c == 0); i_qbit_num = 6'd4;
            if (prev_stall) begin
                stall_seen++;
                checks++;
                if (o_amp_valid !== 1'b1 || o_amp_data !== pd || o_amp_index !== pi ||
                    o_amp_last !== pl) begin
                    errors++;
                    $display("FAIL bp_stable c=%0d: valid=%b idx=%0d data=%h, required 1 idx=%0d data=%h",
                             c, o_amp_valid, o_amp_index, o_amp_data, pi, pd);
                end
            end
            if (o_amp_valid && o_amp_index == 18'd1 && !stall_done) begin
                stall_left = 5; stall_done = 1;
            end
            if (stall_left > 0) begin
                i_amp_ready = 1'b0; stall_left--;
            end else if (stall_done) begin
                i_amp_ready = 1'($urandom_range(0, 1));
            end else begin
                i_amp_ready = 1'b1;
            end
            if (o_amp_valid && i_amp_ready) begin
                checks++;
                if (o_amp_index !== 18'(beats) || o_amp_data !== amp(beats) ||
                    o_amp_last !== (beats == 15)) begin
                    errors++;
                    $display("FAIL bp_beat %0d: idx=%0d data=%h last=%b, required idx=%0d data=%h",
                             beats, o_amp_index, o_amp_data, o_amp_last, beats, amp(beats));
                end
                beats++;
            end
            prev_stall = o_amp_valid && !i_amp_ready;
            pd = o_amp_data; pi = o_amp_index; pl = o_amp_last;
            if (o_done) begin done_seen = 1; break; end
        end
        i_start = 1'b0; i_amp_ready = 1'b1;
        checks++;
        if (!done_seen || beats != 16 || rd_cnt != 4 || rd_bad != 0) begin
            errors++;
            $display("FAIL bp_totals: done=%b beats=%0d reads=%0d bad=%0d, required 1/16/4/0",
                     done_seen, beats, rd_cnt, rd_bad);
        end
        checks++;
        if (stall_seen < 5) begin
            errors++;
            $display("FAIL bp_stall_hold: stalled valid cycles=%0d, required >=5", stall_seen);
        end
    endtask

    task automatic test_reject;
        int qs[2] = '{1, 19};
        foreach (qs[j]) begin
            clear_mon();
            for (int c = 0; c < 4; c++) begin
                tick();
                i_start = (c == 0); i_qbit_num = QW'(qs[j]);
                checks++;
                if (o_err !== (c == 1) || o_busy !== 1'b0 || o_state_ena !== '0) begin
                    errors++;
                    $display("FAIL reject q=%0d c=%0d: err=%b busy=%b ena=%h, required err=%b busy=0 ena=0",
                             qs[j], c, o_err, o_busy, o_state_ena, (c == 1));
                end
            end
            i_start = 1'b0;
            checks++;
            if (rd_cnt != 0 || err_cnt != 1) begin
                errors++;
                $display("FAIL reject_totals q=%0d: reads=%0d errs=%0d, required 0/1", qs[j], rd_cnt, err_cnt);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int beats = 0; bit poked = 0, done_seen = 0;
        clear_mon();
        for (int c = 0; c < 100; c++) begin
            tick();
            i_amp_ready = 1'b1;
            i_start = (c == 0); i_qbit_num = 6'd3;
            if (o_amp_valid && o_amp_index == 18'd1 && !poked) begin
                i_start = 1'b1; i_qbit_num = 6'd2; poked = 1;
            end
            if (o_amp_valid) begin
                checks++;
                if (o_amp_index !== 18'(beats) || o_amp_data !== amp(beats)) begin
                    errors++;
                    $display("FAIL busy_start_beat %0d: idx=%0d data=%h, required idx=%0d data=%h",
                             beats, o_amp_index, o_amp_data, beats, amp(beats));
                end
                beats++;
            end
            if (o_done) begin done_seen = 1; break; end
        end
        i_start = 1'b0;
        repeat (4) tick();
        checks++;
        if (!done_seen || beats != 8 || rd_cnt != 2 || err_cnt != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_totals: done=%b beats=%0d reads=%0d errs=%0d busy=%b, required 1/8/2/0/0",
                     done_seen, beats, rd_cnt, err_cnt, o_busy);
        end
    endtask

    task automatic test_abort;
        bit aborted = 0;
        clear_mon();
        for (int c = 0; c < 100; c++) begin
            tick();
            i_start = (c == 0); i_qbit_num = 6'd4; i_amp_ready = 1'b1;
            i_abort = 1'b0;
            if (o_amp_valid && o_amp_index == 18'd13) begin
                i_abort = 1'b1; aborted = 1; break;
            end
        end
        i_start = 1'b0;
        tick();
        i_abort = 1'b0;
        checks++;
        if (!aborted || o_busy !== 1'b0 || o_amp_valid !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: reached=%b busy=%b valid=%b done=%b, required 1/0/0/0",
                     aborted, o_busy, o_amp_valid, o_done);
        end
        repeat (4) tick();
        checks++;
        if (done_cnt != 0 || last_cnt != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: dones=%0d lasts=%0d busy=%b, required 0/0/0", done_cnt, last_cnt, o_busy);
        end
        clear_mon();
        run_start(2, 12);
        checks++;
        if (rd_cnt != 1 || rd_bad != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL abort_restart: reads=%0d bad=%0d dones=%0d, required 1/0/1", rd_cnt, rd_bad, done_cnt);
        end
    endtask

    task automatic test_reset_mid;
        clear_mon();
        for (int c = 0; c < 10; c++) begin
            tick();
            i_start = (c == 0); i_qbit_num = 6'd3; i_amp_ready = 1'b1;
        end
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_state_addra !== 16'd1) begin
            errors++;
            $display("FAIL rst_pre_wait: busy=%b addr=%0d, required 1/1", o_busy, o_state_addra);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({o_busy, o_done, o_err, o_state_ena, o_state_wea, o_state_addra,
             o_amp_valid, o_amp_index, o_amp_last, o_amp_data} !== '0) begin
            errors++;
            $display("FAIL rst_mid: busy=%b addr=%0d idx=%0d data=%h, required all 0",
                     o_busy, o_state_addra, o_amp_index, o_amp_data);
        end
        tick();
        rst = 1'b0;
        tick();
        clear_mon();
        run_start(2, 12);
        checks++;
        if (rd_cnt != 1 || rd_bad != 0 || done_cnt != 1 || wea_bad != 0) begin
            errors++;
            $display("FAIL rst_restart: reads=%0d bad=%0d dones=%0d wea_bad=%0d, required 1/0/1/0",
                     rd_cnt, rd_bad, done_cnt, wea_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_14();
        test_backpressure();
        test_reject();
        test_start_while_busy();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/qea_state_reader.md
# qea_state_reader

Host-side readback engine for the QEA state RAM. After a circuit run completes, it walks every state-RAM word in ascending address order. Each `PE_NUM*STATE_DATA_WIDTH` word is split into `PE_NUM` complex amplitudes, which are emitted one per beat on a valid/ready stream with a global amplitude index. It drives the same `i_state_ena/i_state_wea/i_state_addra` port group of QEA that the state loader writes through, and consumes `o_state_dout`.

## Interface
- `PE_NUM_WIDTH`, 2: log2 of PE_NUM.
- `PE_NUM`, 4: amplitudes per state-RAM word.
- `STATE_DATA_WIDTH`, 64: one complex amplitude ({re[63:32], im[31:0]}, Q2.30).
- `STATE_ADDR_WIDTH`, 16: state-RAM address width.
- `MAX_QBIT_WIDTH`, 6: width of qubit count.
- `RD_LATENCY`, 2: cycles from enable to valid `i_state_dout`, ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_start` in 1: begin readback; sampled only in IDLE.
- `i_qbit_num` in MAX_QBIT_WIDTH: qubit count, sampled with `i_start`.
- `i_abort` in 1: synchronous abort to IDLE.
- `o_busy` out 1: high in any state other than IDLE.
- `o_done` out 1: one-cycle pulse after the final beat.
- `o_err` out 1: one-cycle pulse on a rejected start.
- `o_state_ena` out PE_NUM: per-PE read enable; all ones for one cycle per word.
- `o_state_wea` out PE_NUM: constant 0.
- `o_state_addra` out STATE_ADDR_WIDTH: word address.
- `i_state_dout` in PE_NUM*STATE_DATA_WIDTH: QEA read data.
- `o_amp_valid` out 1, `i_amp_ready` in 1: stream handshake.
- `o_amp_data` out STATE_DATA_WIDTH: amplitude.
- `o_amp_index` out STATE_ADDR_WIDTH+PE_NUM_WIDTH: global index, equal to addr*PE_NUM + k.
- `o_amp_last` out 1: high on the final amplitude only.

## Operation
- **Word count.** N = 2^(i_qbit_num − PE_NUM_WIDTH).
- **Valid start.** A start is valid when PE_NUM_WIDTH ≤ i_qbit_num ≤ PE_NUM_WIDTH+STATE_ADDR_WIDTH.
- **Rejected start.** Otherwise the block pulses `o_err` and stays in IDLE. No RAM access occurs.
- **FSM states.** IDLE → READ → WAIT → EMIT → (READ | FINISH) → IDLE.
- **READ.** One cycle. `o_state_ena` is all ones and `o_state_addra` = current address.
- **WAIT.** Lasts RD_LATENCY cycles, counted by a down-counter. `i_state_dout` is captured into a word buffer on the last WAIT edge.
- **EMIT.** k = 0..PE_NUM−1 are emitted in order. Beat k carries slice `[(PE_NUM−k)*W−1 -: W]`, so the MSB slice goes first; k=0 is amplitude addr*PE_NUM.
  - Advance k only on `o_amp_valid && i_amp_ready`.
  - After beat PE_NUM−1 transfers: if addr = N−1, go to FINISH; otherwise increment addr and go to READ.
- **FINISH.** One cycle. Pulse `o_done`, then return to IDLE.
- **Address wrap.** The address is held in STATE_ADDR_WIDTH+1 bits internally, so N = 2^STATE_ADDR_WIDTH terminates and does not wrap.
- **Abort.** `i_abort` in any non-IDLE state returns to IDLE on the next edge.
  - `o_amp_valid` drops, and no `o_done` or `o_last` is generated.
  - Abort in IDLE has no effect.
  - Abort takes priority over a simultaneous handshake.
- **Start while busy.** Ignored.

## Timing
- **Reset values.** While `rst` is high, all outputs are 0 immediately (asynchronous), the FSM is in IDLE and all counters are 0.
- **Reset mid-operation.** Abandons the transfer. The next start restarts at address 0.
- **Start latency.** With `i_start` high in cycle 0:
  - `o_state_ena` is high in cycle 1 with addr 0.
  - Data is captured at the end of cycle 1+RD_LATENCY.
  - `o_amp_valid` is first high in cycle 2+RD_LATENCY.
- **Per-word cost.** With `i_amp_ready` held at 1, each word takes 1+RD_LATENCY+PE_NUM cycles. Beats are back-to-back within a word, and there is a gap of 1+RD_LATENCY cycles between words.
- **Done timing.** `o_done` is high in the cycle after the final handshake. `o_busy` falls in the cycle after `o_done`.
- **Stream stability.** While `o_amp_valid && !i_amp_ready`, `o_amp_data`, `o_amp_index` and `o_amp_last` hold constant. `o_amp_valid` never deasserts without a handshake, except on abort or reset.
- **Read enable.** `o_state_ena` is never asserted outside READ. `o_state_wea` is never nonzero.

## Test plan
- **Basic 2-qubit readback.** qbit_num=2, RD_LATENCY=2, word0 = {64'h40000000_00000000, 0, 0, 0}, ready=1, start in cycle 0.
  - `o_state_ena` = 4'hF in cycle 1 only.
  - Beats occur in cycles 4–7: data 40000000_00000000 then three zeros, indices 0..3.
  - `o_amp_last` is high in cycle 7 and `o_done` in cycle 8.
- **Full 14-qubit readback.** qbit_num=14 with word w preloaded to distinct patterns, ready=1.
  - Addresses 0..4095 are read exactly once, in order.
  - 16384 beats are emitted, with index equal to the beat count.
  - `o_amp_last` is high only at index 16383.
  - `o_done` occurs 28672 cycles after the first READ cycle.
- **Backpressure.** Hold ready=0 for 5 cycles mid-word, then randomize ready at 50%.
  - Outputs stay stable while stalled.
  - No beat is lost or duplicated, and the index sequence is unchanged.
- **Rejected and ignored starts.** qbit_num=1 and qbit_num=19.
  - Each gives an `o_err` pulse for 1 cycle with `o_busy`=0 and no enable.
  - A start pulse during EMIT of a valid run is ignored and the run completes normally.
- **Abort and reset mid-run.**
  - Abort during EMIT of word 3: IDLE next cycle, with no `o_done` or `o_last`.
  - `rst` pulsed mid-WAIT: all outputs 0 in the same cycle.
  - In both cases the following start reads from addr 0.
